gpio_add_core: RTL and testbench

GPIO_ADD_CORE -- requirements
Module: gpio_add_core

---
 rtl/gpio_add_pkg.sv | 27 ++
 rtl/gpio_add_if.sv | 34 +++
 rtl/io_sync_edge.sv | 36 +++
 rtl/gpio_add_core.sv | 141 ++++++++++++++
 tb/tb_gpio_add_core.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_add_pkg.sv
// Shared types and constants for the GPIO two-operand adder.
// Pad bit positions and the fixed output-enable pattern live here.
package gpio_add_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_B  = 2'd1,
    COMPUTE = 2'd2
  } state_e;

  localparam int IO_IN_W   = 3;
  localparam int IO_OUT_W  = 2;
  localparam int IO_OEB_W  = 5;
  localparam int IO_STB    = 0;
  localparam int IO_OP_LSB = 1;
  localparam int IO_OP_MSB = 2;

  localparam logic [IO_OEB_W-1:0] IO_OEB = 5'b11100;

  function automatic logic [2:0] add_ops(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/gpio_add_if.sv
// Pad-side bundle of the adder core.
// The core sits on the slave side; pads/bench drive the master side.
interface gpio_add_if;
  import gpio_add_pkg::*;

  logic [IO_IN_W-1:0]  io_in;
  logic [IO_OUT_W-1:0] io_out;
  logic [IO_OEB_W-1:0] io_oeb;
  logic                carry;
  logic                done;
  logic                busy;
  logic                timeout;

  modport slave (
    input  io_in,
    output io_out,
    output io_oeb,
    output carry,
    output done,
    output busy,
    output timeout
  );

  modport master (
    output io_in,
    input  io_out,
    input  io_oeb,
    input  carry,
    input  done,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/io_sync_edge.sv
// Multi-flop pad synchronizer with rising-edge detect on bit 0.
// Bit 0 is consumed only as an edge; upper bits come out as levels.
module io_sync_edge #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:1] sync_data,
  output logic             rise
);

  logic [WIDTH-1:0] stg [DEPTH];
  logic             prev;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
      prev <= 1'b0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
      prev <= stg[DEPTH-1][0];
    end
  end

  // prev starts at 0, so a strobe already high at release is one event
  assign rise      = stg[DEPTH-1][0] & ~prev;
  assign sync_data = stg[DEPTH-1][WIDTH-1:1];

endmodule

// File: rtl/gpio_add_core.sv
// Pad-driven adder: strobe in A, strobe in B, present A+B on pads.
// A missing B strobe is abandoned after TIMEOUT_CYC cycles.
module gpio_add_core
  import gpio_add_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic        clock,
  input  logic        resetb,
  gpio_add_if.slave   bus
);

  localparam int CNT_W =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic [IO_OP_MSB:IO_OP_LSB] op;
  logic                       rise;

  state_e         state_q;
  state_e         state_d;
  logic [1:0]     op_a_q;
  logic [1:0]     op_b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]     sum_q;
  logic           done_q;
  logic           busy_q;
  logic           tmo_q;

  logic cap_a;
  logic cap_b;
  logic fire_sum;
  logic fire_tmo;
  logic tmo_hit;

  io_sync_edge #(
    .WIDTH (IO_IN_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .resetb    (resetb),
    .din       (bus.io_in),
    .sync_data (op),
    .rise      (rise)
  );

  assign tmo_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // timeout is checked first so a coincident strobe is dropped
  always_comb begin
    state_d  = state_q;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    fire_sum = 1'b0;
    fire_tmo = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          cap_a   = 1'b1;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (tmo_hit) begin
          fire_tmo = 1'b1;
          state_d  = IDLE;
        end else if (rise) begin
          cap_b   = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        fire_sum = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      op_a_q <= '0;
      op_b_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (cap_a) begin
        op_a_q <= op;
      end else if (fire_tmo) begin
        op_a_q <= '0;
      end
      if (cap_b) begin
        op_b_q <= op;
      end
      if (cap_a) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_B) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sum_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      if (fire_sum) begin
        sum_q <= add_ops(op_a_q, op_b_q);
      end
      done_q <= fire_sum;
      tmo_q  <= fire_tmo;
      busy_q <= (state_d != IDLE);
    end
  end

  assign bus.io_out  = sum_q[1:0];
  assign bus.carry   = sum_q[2];
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = tmo_q;
  assign bus.io_oeb  = IO_OEB;

endmodule

// File: tb/tb_gpio_add_core.sv
// Randomized bench for gpio_add_core against a pad-level reference.
// Model works on delayed pad samples and the adder's transaction rules.
module tb_gpio_add_core;
  import gpio_add_pkg::*;

  localparam int S = 2;
  localparam int T = 1000;

  logic clock  = 1'b0;
  logic resetb = 1'b0;

  gpio_add_if io ();

  gpio_add_core #(
    .SYNC_STAGES (S),
    .TIMEOUT_CYC (T)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (io)
  );

  always #5 clock = ~clock;

  int n_run  = 0;
  int n_fail = 0;
  int edge_no = 0;
  int dn_cnt  = 0;
  int to_cnt  = 0;

  typedef enum int { M_IDLE, M_WAIT, M_SUM } mode_e;

  logic [2:0] hist [$];
  mode_e      m_mode;
  int         m_age;
  logic [1:0] m_a, m_b;
  logic [2:0] m_sum;
  logic       m_done, m_tmo;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               tag, got, exp, edge_no);
    end
  endtask

  function automatic void m_reset();
    hist = {};
    for (int i = 0; i <= S; i++) hist.push_back(3'b000);
    m_mode = M_IDLE;
    m_age  = 0;
    m_a    = '0;
    m_b    = '0;
    m_sum  = '0;
    m_done = 1'b0;
    m_tmo  = 1'b0;
  endfunction

  // hist[1] is the pad value S edges ago, hist[0] one edge earlier
  function automatic void m_step(input logic [2:0] pad);
    logic [2:0] cur, prv;
    logic       ev;
    cur = hist[1];
    prv = hist[0];
    ev  = cur[0] & ~prv[0];
    m_done = 1'b0;
    m_tmo  = 1'b0;
    case (m_mode)
      M_SUM: begin
        m_sum  = m_a + m_b;
        m_sum  = 3'(int'(m_a) + int'(m_b));
        m_done = 1'b1;
        m_mode = M_IDLE;
      end
      M_WAIT: begin
        if (m_age == T - 1) begin
          m_tmo  = 1'b1;
          m_mode = M_IDLE;
        end else if (ev) begin
          m_b    = cur[2:1];
          m_mode = M_SUM;
        end else begin
          m_age++;
        end
      end
      default: begin
        if (ev) begin
          m_a    = cur[2:1];
          m_age  = 0;
          m_mode = M_WAIT;
        end
      end
    endcase
    hist.push_back(pad);
    void'(hist.pop_front());
  endfunction

  task automatic check_outs();
    chk("io_out",  32'(io.io_out),  32'(m_sum[1:0]));
    chk("carry",   32'(io.carry),   32'(m_sum[2]));
    chk("done",    32'(io.done),    32'(m_done));
    chk("timeout", 32'(io.timeout), 32'(m_tmo));
    chk("busy",    32'(io.busy),    32'(m_mode != M_IDLE));
    chk("io_oeb",  32'(io.io_oeb),  32'h1c);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_no++;
    if (!resetb) m_reset();
    else m_step(io.io_in);
    if (io.done === 1'b1) dn_cnt++;
    if (io.timeout === 1'b1) to_cnt++;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      io.io_in = {2'($urandom), 1'b0};
      tick();
    end
  endtask

  task automatic strobe(input logic [1:0] op, input int hold);
    io.io_in = {op, 1'b1};
    for (int i = 0; i < hold; i++) tick();
    io.io_in = {op, 1'b0};
    tick();
  endtask

  initial begin
    int e0, e_obs, d0, t0, lat;
    bit seen;

    io.io_in = 3'b000;
    m_reset();
    #1;
    chk("rst_io_out", 32'(io.io_out), 0);
    chk("rst_busy",   32'(io.busy),   0);
    tick();
    tick();
    resetb = 1'b1;
    idle(4);

    // A=01, B=10
    d0 = dn_cnt;
    strobe(2'b01, 1);
    idle(3);
    strobe(2'b10, 1);
    idle(6);
    chk("r31_out",   32'(io.io_out), 32'h3);
    chk("r31_carry", 32'(io.carry),  0);
    chk("r31_busy",  32'(io.busy),   0);
    chk("r31_done",  32'(dn_cnt - d0), 1);

    // A=11, B=11 with latency measured from B pad edge
    strobe(2'b11, 1);
    idle(3);
    io.io_in = 3'b111;
    e0 = edge_no + 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      io.io_in = 3'b110;
      if (io.done === 1'b1) begin
        seen  = 1;
        e_obs = edge_no;
      end
    end
    chk("r32_seen", 32'(seen), 1);
    lat = seen ? (e_obs - e0 + 1) : -1;
    chk("r32_lat",   32'(lat), 32'(S + 2));
    chk("r32_out",   32'(io.io_out), 32'h2);
    chk("r32_carry", 32'(io.carry),  1);
    idle(3);

    // A=10 with no B: timeout after T waiting cycles
    io.io_in = 3'b101;
    e0 = edge_no + 1;
    tick();
    io.io_in = 3'b100;
    seen = 0;
    for (int i = 0; i < T + 20 && !seen; i++) begin
      tick();
      if (io.timeout === 1'b1) begin
        seen  = 1;
        e_obs = edge_no;
      end
    end
    chk("r33_seen", 32'(seen), 1);
    chk("r33_edge", 32'(seen ? e_obs - e0 : -1), 32'(S + T));
    chk("r33_busy", 32'(io.busy), 0);
    chk("r33_out",  32'(io.io_out), 32'h2);
    chk("r33_cy",   32'(io.carry),  1);
    idle(3);

    // held strobe counts once
    d0 = dn_cnt;
    strobe(2'b01, 50);
    idle(3);
    strobe(2'b01, 1);
    idle(6);
    chk("r34_sum",  32'({io.carry, io.io_out}), 32'h2);
    chk("r34_done", 32'(dn_cnt - d0), 1);

    // reset while waiting for B, strobe held through release
    strobe(2'b10, 1);
    idle(5);
    chk("r35_wait", 32'(io.busy), 1);
    d0 = dn_cnt;
    t0 = to_cnt;
    #2 resetb = 1'b0;
    #1;
    chk("r35_rst_out",  32'({io.carry, io.io_out}), 0);
    chk("r35_rst_busy", 32'(io.busy), 0);
    m_reset();
    io.io_in = 3'b001;
    tick();
    tick();
    resetb = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    io.io_in = 3'b000;
    tick();
    strobe(2'b01, 1);
    idle(6);
    chk("r35_out",  32'(io.io_out), 32'h1);
    chk("r35_done", 32'(dn_cnt - d0), 1);
    chk("r35_tmo",  32'(to_cnt - t0), 0);

    // B strobe lands exactly on the timeout cycle
    io.io_in = 3'b101;
    tick();
    io.io_in = 3'b100;
    for (int i = 0; i < T - 1; i++) tick();
    io.io_in = 3'b011;
    t0 = to_cnt;
    d0 = dn_cnt;
    for (int i = 0; i < 2 * S + 4; i++) tick();
    chk("r36_tmo",  32'(to_cnt - t0), 1);
    chk("r36_busy", 32'(io.busy), 0);
    idle(5);
    chk("r36_nocap", 32'(io.busy), 0);
    chk("r36_done",  32'(dn_cnt - d0), 0);

    // random transactions
    for (int n = 0; n < 40; n++) begin
      strobe(2'($urandom), $urandom_range(1, 4));
      idle($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) idle(T + 5);
      else strobe(2'($urandom), $urandom_range(1, 4));
      idle($urandom_range(0, 6));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
